// File: rtl/transition_counter.sv
`default_nettype none
// ============================================================================
// Module      : transition_counter
// Description : Counts transitions of a synchronous 1-bit input seen between
//               consecutive rising clock edges. The count wraps or saturates.
// Revision    : 1.0
// ============================================================================
module transition_counter #(
   parameter int WIDTH     = 64,
   parameter int EDGE_MODE = 0,
   parameter int SATURATE  = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in,
   output logic [WIDTH-1:0] o
);

   logic [WIDTH-1:0] r_count;
   logic             r_prev;
   logic             w_rise;
   logic             w_fall;
   logic             w_hit;
   logic             w_at_max;
   logic [WIDTH-1:0] w_next;

   assign w_rise   = in & ~r_prev;
   assign w_fall   = ~in & r_prev;
   assign w_at_max = &r_count;

   generate
      if (EDGE_MODE == 1) begin : g_rise_only
         assign w_hit = w_rise;
      end else if (EDGE_MODE == 2) begin : g_fall_only
         assign w_hit = w_fall;
      end else begin : g_both_edges
         assign w_hit = w_rise | w_fall;
      end
   endgenerate

   // Saturating variant suppresses the increment at all-ones; wrap variant rolls over.
   generate
      if (SATURATE != 0) begin : g_saturate
         assign w_next = (w_hit && !w_at_max) ? r_count + 1'b1 : r_count;
      end else begin : g_wrap
         assign w_next = w_hit ? r_count + 1'b1 : r_count;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
         r_prev  <= in;
      end else begin
         r_count <= w_next;
         r_prev  <= in;
      end
   end

   assign o = r_count;

endmodule
`default_nettype wire

// File: tb/tb_transition_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_transition_counter
// Description : Scoreboard bench driving five counter variants with a shared
//               directed input sequence and hand-computed expected counts.
// Revision    : 1.0
// ============================================================================
module tb_transition_counter;

   logic        clk;
   logic        reset;
   logic        in;
   logic [63:0] w_o0;
   logic [63:0] w_o1;
   logic [63:0] w_o2;
   logic [3:0]  w_ow;
   logic [3:0]  w_os;

   // dut 0: both edges, 1: rising, 2: falling, 3: 4-bit wrap, 4: 4-bit saturate
   transition_counter #(.WIDTH(64), .EDGE_MODE(0), .SATURATE(0)) u_dut0 (
      .clk(clk), .reset(reset), .in(in), .o(w_o0));
   transition_counter #(.WIDTH(64), .EDGE_MODE(1), .SATURATE(0)) u_dut1 (
      .clk(clk), .reset(reset), .in(in), .o(w_o1));
   transition_counter #(.WIDTH(64), .EDGE_MODE(2), .SATURATE(0)) u_dut2 (
      .clk(clk), .reset(reset), .in(in), .o(w_o2));
   transition_counter #(.WIDTH(4), .EDGE_MODE(0), .SATURATE(0)) u_dutw (
      .clk(clk), .reset(reset), .in(in), .o(w_ow));
   transition_counter #(.WIDTH(4), .EDGE_MODE(0), .SATURATE(1)) u_duts (
      .clk(clk), .reset(reset), .in(in), .o(w_os));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          idx;
      logic [63:0] exp;
      string       nm;
   } sb_t;

   sb_t q[$];
   int  n_pass  = 0;
   int  n_total = 0;

   function automatic logic [63:0] dut_out(int idx);
      case (idx)
         0:       return w_o0;
         1:       return w_o1;
         2:       return w_o2;
         3:       return {60'd0, w_ow};
         default: return {60'd0, w_os};
      endcase
   endfunction

   task automatic expect_o(int idx, logic [63:0] v, string nm);
      sb_t e;
      e.idx = idx;
      e.exp = v;
      e.nm  = nm;
      q.push_back(e);
   endtask

   task automatic expect_all(logic [63:0] v0, logic [63:0] v1, logic [63:0] v2,
                             logic [63:0] vw, logic [63:0] vs, string nm);
      expect_o(0, v0, nm);
      expect_o(1, v1, nm);
      expect_o(2, v2, nm);
      expect_o(3, vw, nm);
      expect_o(4, vs, nm);
   endtask

   // Outputs are registered, so the falling edge is a stable sampling point.
   always @(negedge clk) begin
      sb_t         e;
      logic [63:0] got;
      while (q.size() > 0) begin
         e   = q.pop_front();
         got = dut_out(e.idx);
         n_total++;
         if (got === e.exp) n_pass++;
         else $display("FAIL %s dut%0d: got %0d expected %0d", e.nm, e.idx, got, e.exp);
      end
   end

   task automatic step(logic rst, logic v);
      @(negedge clk);
      reset = rst;
      in    = v;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      in    = 1'b0;

      // basic counting, both edges
      step(1, 0);
      expect_all(0, 0, 0, 0, 0, "reset");
      step(0, 1); expect_o(0, 1, "basic1");
      step(0, 0); expect_o(0, 2, "basic2");
      step(0, 1); expect_o(0, 3, "basic3");
      step(0, 0); expect_o(0, 4, "basic4");
      expect_o(1, 2, "basic_rise");
      expect_o(2, 2, "basic_fall");

      // glitch between edges with the same level sampled on both sides
      step(0, 1); expect_o(0, 5, "glitch_pre");
      #2 in = 1'b0;
      #1 in = 1'b1;
      @(posedge clk); #1;
      expect_o(0, 5, "glitch_hold");
      step(0, 0); expect_o(0, 6, "glitch_post");

      // level captured during reset is the baseline
      step(1, 1); expect_o(0, 0, "rstcap_rst");
      for (int i = 0; i < 3; i++) begin
         step(0, 1); expect_o(0, 0, "rstcap_hold");
      end
      step(0, 0);
      expect_o(0, 1, "rstcap_fall");
      expect_o(1, 0, "rstcap_rise_only");
      expect_o(2, 1, "rstcap_fall_only");

      // edge modes: six toggles from 0
      step(1, 0);
      for (int i = 0; i < 6; i++) step(0, ((i % 2) == 0));
      expect_all(6, 3, 3, 6, 6, "modes");

      // overflow of the 4-bit variants: 17 toggles
      step(1, 0);
      for (int i = 0; i < 15; i++) step(0, ((i % 2) == 0));
      expect_o(3, 15, "ovf15_wrap");
      expect_o(4, 15, "ovf15_sat");
      step(0, 0);
      expect_o(3, 0, "ovf16_wrap");
      expect_o(4, 15, "ovf16_sat");
      step(0, 1);
      expect_all(17, 9, 8, 1, 15, "ovf17");

      // mid-run reset on an edge where in also toggles
      step(1, 0);
      for (int i = 0; i < 5; i++) step(0, ((i % 2) == 0));
      expect_o(0, 5, "mid_count");
      step(1, 0); expect_all(0, 0, 0, 0, 0, "mid_rst");
      step(0, 1); expect_o(0, 1, "mid_resume");

      // reset held while in moves; baseline is the last reset-edge level
      step(1, 0); expect_o(0, 0, "hold_rst1");
      step(1, 1); expect_o(0, 0, "hold_rst2");
      step(0, 1); expect_o(0, 0, "hold_same");
      step(0, 0); expect_o(0, 1, "hold_fall");

      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      if (q.size() != 0) begin
         n_total++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
